// File: rtl/tmr_pkg.sv
// Shared types and constants for the TMR fault-injection source and its voter.
package tmr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    INJECT = 2'd2
  } inj_state_t;

  localparam logic [1:0] LANE_NONE = 2'd0;
  localparam logic [1:0] LANE_1    = 2'd1;
  localparam logic [1:0] LANE_2    = 2'd2;
  localparam logic [1:0] LANE_3    = 2'd3;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  // bit 0 drives data_1, bit 2 drives data_3
  function automatic logic [2:0] lane_onehot(input logic [1:0] lane);
    case (lane)
      LANE_1:  return 3'b001;
      LANE_2:  return 3'b010;
      LANE_3:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/tmr_inj_ctrl.sv
// Injection campaign sequencer: latches the campaign config, counts clean and
// corrupt words on accepted handshakes only, and keeps a saturating tally.
//
//   state  | meaning
//   IDLE   | no campaign armed; inj_start with lane != 0 and len != 0 arms one
//   DELAY  | passing delay_cnt clean words before corruption begins
//   INJECT | every accepted word is corrupted on the latched lane
module tmr_inj_ctrl
  import tmr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             inj_start,
  input  logic [1:0]       inj_lane,
  input  logic [WIDTH-1:0] inj_mask,
  input  logic [CNT_W-1:0] inj_delay,
  input  logic [CNT_W-1:0] inj_len,
  output logic [2:0]       corrupt_lane,
  output logic [WIDTH-1:0] mask,
  output logic             inj_active,
  output logic             inj_done,
  output logic [CNT_W-1:0] inj_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  inj_state_t       state;
  logic [1:0]       lane;
  logic [CNT_W-1:0] delay_cnt;
  logic [CNT_W-1:0] len_cnt;

  always_comb begin
    corrupt_lane = 3'b000;
    if (state == INJECT) corrupt_lane = lane_onehot(lane);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lane       <= LANE_NONE;
      mask       <= '0;
      delay_cnt  <= '0;
      len_cnt    <= '0;
      inj_active <= 1'b0;
      inj_done   <= 1'b0;
      inj_count  <= '0;
    end else begin
      inj_done <= 1'b0;
      if (accept && state == INJECT && inj_count != '1)
        inj_count <= inj_count + CNT_ONE;
      case (state)
        IDLE: begin
          // a word accepted alongside the start is still clean
          if (inj_start && inj_lane != LANE_NONE && inj_len != '0) begin
            lane      <= inj_lane;
            mask      <= inj_mask;
            delay_cnt <= inj_delay;
            len_cnt   <= inj_len;
            if (inj_delay == '0) begin
              state      <= INJECT;
              inj_active <= 1'b1;
            end else begin
              state <= DELAY;
            end
          end
        end
        DELAY: begin
          if (accept) begin
            delay_cnt <= delay_cnt - CNT_ONE;
            if (delay_cnt == CNT_ONE) begin
              state      <= INJECT;
              inj_active <= 1'b1;
            end
          end
        end
        INJECT: begin
          if (accept) begin
            len_cnt <= len_cnt - CNT_ONE;
            if (len_cnt == CNT_ONE) begin
              state      <= IDLE;
              inj_active <= 1'b0;
              inj_done   <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          inj_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tmr_fault_injector.sv
// Source side of the TMR voter path: one-slot output register feeding three
// replicas, one of which may be XOR-corrupted by the injection controller.
module tmr_fault_injector
  import tmr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             inj_start,
  input  logic [1:0]       inj_lane,
  input  logic [WIDTH-1:0] inj_mask,
  input  logic [CNT_W-1:0] inj_delay,
  input  logic [CNT_W-1:0] inj_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_1,
  output logic [WIDTH-1:0] data_2,
  output logic [WIDTH-1:0] data_3,
  output logic             inj_active,
  output logic             inj_done,
  output logic [CNT_W-1:0] inj_count
);

  logic             accept;
  logic [2:0]       corrupt_lane;
  logic [WIDTH-1:0] mask;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  tmr_inj_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .accept       (accept),
    .inj_start    (inj_start),
    .inj_lane     (inj_lane),
    .inj_mask     (inj_mask),
    .inj_delay    (inj_delay),
    .inj_len      (inj_len),
    .corrupt_lane (corrupt_lane),
    .mask         (mask),
    .inj_active   (inj_active),
    .inj_done     (inj_done),
    .inj_count    (inj_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_1    <= '0;
      data_2    <= '0;
      data_3    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      data_1    <= in_data ^ ({WIDTH{corrupt_lane[0]}} & mask);
      data_2    <= in_data ^ ({WIDTH{corrupt_lane[1]}} & mask);
      data_3    <= in_data ^ ({WIDTH{corrupt_lane[2]}} & mask);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
